// File: rtl/vmem_wr_arb.sv
// vmem_wr_arb: owner of the framebuffer write port. Arbitrates between CPU
// pixel writes and a rectangle-fill engine that walks a clamped box in raster
// order. Contended cycles alternate 1:1 via a round-robin pointer. The winning
// write is registered onto the vmem_* outputs one cycle after the grant.
module vmem_wr_arb #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int AW_H  = 10,
    parameter int AW_V  = 9,
    parameter int DW    = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_we_i,
    input  logic [AW_H-1:0] cpu_addr_h_i,
    input  logic [AW_V-1:0] cpu_addr_v_i,
    input  logic [DW-1:0]   cpu_wdata_i,
    output logic            cpu_ready_o,
    input  logic            fill_start_i,
    input  logic [AW_H-1:0] fill_x0_i,
    input  logic [AW_V-1:0] fill_y0_i,
    input  logic [AW_H-1:0] fill_x1_i,
    input  logic [AW_V-1:0] fill_y1_i,
    input  logic [DW-1:0]   fill_color_i,
    output logic            fill_busy_o,
    output logic            fill_done_o,
    output logic            vmem_we_o,
    output logic [AW_H-1:0] vmem_waddr_h_o,
    output logic [AW_V-1:0] vmem_waddr_v_o,
    output logic [DW-1:0]   vmem_wdata_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW_H-1:0] X_MAX = AW_H'(H_RES - 1);
    localparam logic [AW_V-1:0] Y_MAX = AW_V'(V_RES - 1);

    state_t          state;
    logic [AW_H-1:0] x0_q;
    logic [AW_H-1:0] xe_q;
    logic [AW_V-1:0] ye_q;
    logic [AW_H-1:0] cx;
    logic [AW_V-1:0] cy;
    logic [DW-1:0]   color_q;
    logic            rr_cpu;

    logic [AW_H-1:0] xe_clamp;
    logic [AW_V-1:0] ye_clamp;
    logic            start_empty;
    logic            fill_req;
    logic            grant_cpu;
    logic            grant_fill;

    // Clamp the requested rectangle to the screen and detect an empty box.
    // x0 > X_MAX is the same test as x0 >= H_RES at this width.
    always_comb begin
        xe_clamp    = (fill_x1_i > X_MAX) ? X_MAX : fill_x1_i;
        ye_clamp    = (fill_y1_i > Y_MAX) ? Y_MAX : fill_y1_i;
        start_empty = (fill_x0_i > xe_clamp) || (fill_y0_i > ye_clamp) ||
                      (fill_x0_i > X_MAX)    || (fill_y0_i > Y_MAX);
    end

    // Arbitration: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        fill_req   = (state == S_FILL);
        grant_cpu  = cpu_we_i && (!fill_req || rr_cpu);
        grant_fill = fill_req && (!cpu_we_i || !rr_cpu);
    end

    assign cpu_ready_o = cpu_we_i && grant_cpu;
    assign fill_busy_o = (state != S_IDLE);
    assign fill_done_o = (state == S_DONE);

    // Round-robin pointer: flips only after a contended grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_cpu <= 1'b1;
        end else if (cpu_we_i && fill_req) begin
            rr_cpu <= ~rr_cpu;
        end
    end

    // Fill engine: latch the clamped box on start, then step the raster on each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            x0_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            cx      <= '0;
            cy      <= '0;
            color_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fill_start_i) begin
                        x0_q    <= fill_x0_i;
                        xe_q    <= xe_clamp;
                        ye_q    <= ye_clamp;
                        cx      <= fill_x0_i;
                        cy      <= fill_y0_i;
                        color_q <= fill_color_i;
                        state   <= start_empty ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (grant_fill) begin
                        if (cx == xe_q) begin
                            cx <= x0_q;
                            if (cy == ye_q) begin
                                state <= S_DONE;
                            end else begin
                                cy <= cy + 1'b1;
                            end
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Write port register: one-cycle enable per grant; address/data hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vmem_we_o      <= 1'b0;
            vmem_waddr_h_o <= '0;
            vmem_waddr_v_o <= '0;
            vmem_wdata_o   <= '0;
        end else if (grant_cpu) begin
            vmem_we_o      <= 1'b1;
            vmem_waddr_h_o <= cpu_addr_h_i;
            vmem_waddr_v_o <= cpu_addr_v_i;
            vmem_wdata_o   <= cpu_wdata_i;
        end else if (grant_fill) begin
            vmem_we_o      <= 1'b1;
            vmem_waddr_h_o <= cx;
            vmem_waddr_v_o <= cy;
            vmem_wdata_o   <= color_q;
        end else begin
            vmem_we_o      <= 1'b0;
        end
    end

endmodule
